seg_scan_decoder: RTL

- Receive-side counterpart of the CPU's seven-segment scan driver: samples the multiplexed `LED_pos`/`LED_display` bus and rebuilds the 4-digit hex value on screen.
- Outputs a 16-bit word, per-digit decimal points and a frame strobe.
- Sits beside `Multi_circle_CPU` in simulation and on-chip self-check builds, so benches compare numbers instead of segment patterns.

---
 rtl/seg_scan_decoder.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - rebuilds the 4-digit hex value from a multiplexed 7-segment scan bus
// Optional watchdog (stale output) enabled by defining SEGSCAN_STALE_EN.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  LED_pos,
    input  logic [7:0]  LED_display,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        value_changed,
    output logic        decode_err,
    output logic        stale
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [8:0]  SETTLE_W  = 9'(SETTLE_CYCLES);
    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYCLES);

    // input stage (S) and its previous-cycle copy (P) for change detection
    logic [3:0]  pos_s_q, pos_s_d;
    logic [7:0]  disp_s_q, disp_s_d;
    logic [3:0]  pos_p_q, pos_p_d;
    logic [7:0]  disp_p_q, disp_p_d;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [15:0] shadow_nib_q, shadow_nib_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic [3:0]  shadow_err_q, shadow_err_d;
    logic [3:0]  seen_q, seen_d;

    logic [15:0] value_q, value_d;
    logic [3:0]  dp_out_q, dp_out_d;
    logic        err_out_q, err_out_d;
    logic        fv_q, fv_d;
    logic        vc_q, vc_d;

    logic        sel_valid;
    logic [3:0]  sel_mask;
    logic        changed;
    logic [8:0]  cnt_inc;
    logic        capture;
    logic        commit;
    logic [3:0]  glyph_nib;
    logic        glyph_ok;
    logic [15:0] nib_m;
    logic [3:0]  dp_m;
    logic [3:0]  err_m;
    logic [3:0]  seen_m;

    always_comb begin
        pos_s_d  = LED_pos;
        disp_s_d = LED_display;
        pos_p_d  = pos_s_q;
        disp_p_d = disp_s_q;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_mask  = 4'b0000;
        case (pos_s_q)
            4'b1110: begin sel_valid = 1'b1; sel_mask = 4'b0001; end
            4'b1101: begin sel_valid = 1'b1; sel_mask = 4'b0010; end
            4'b1011: begin sel_valid = 1'b1; sel_mask = 4'b0100; end
            4'b0111: begin sel_valid = 1'b1; sel_mask = 4'b1000; end
            default: begin sel_valid = 1'b0; sel_mask = 4'b0000; end
        endcase
    end

    // segments are active-low on the bus; match the active-high {g..a} form
    always_comb begin
        glyph_ok  = 1'b1;
        glyph_nib = 4'h0;
        case (~disp_s_q[6:0])
            7'h3F: glyph_nib = 4'h0;
            7'h06: glyph_nib = 4'h1;
            7'h5B: glyph_nib = 4'h2;
            7'h4F: glyph_nib = 4'h3;
            7'h66: glyph_nib = 4'h4;
            7'h6D: glyph_nib = 4'h5;
            7'h7D: glyph_nib = 4'h6;
            7'h07: glyph_nib = 4'h7;
            7'h7F: glyph_nib = 4'h8;
            7'h6F: glyph_nib = 4'h9;
            7'h77: glyph_nib = 4'hA;
            7'h7C: glyph_nib = 4'hB;
            7'h39: glyph_nib = 4'hC;
            7'h5E: glyph_nib = 4'hD;
            7'h79: glyph_nib = 4'hE;
            7'h71: glyph_nib = 4'hF;
            default: begin
                glyph_nib = 4'h0;
                glyph_ok  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        changed = (pos_s_q != pos_p_q) || (disp_s_q != disp_p_q);
        cnt_inc = {1'b0, cnt_q} + 9'd1;
        if (!sel_valid) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd0;
                end
                ST_SETTLE: begin
                    if (changed) begin
                        cnt_d = 8'd0;
                    end else begin
                        // saturate so a long dwell never wraps back into range
                        cnt_d = cnt_inc[8] ? cnt_q : cnt_inc[7:0];
                        if (cnt_inc == SETTLE_W) begin
                            capture = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (changed) begin
                        state_d = ST_SETTLE;
                        cnt_d   = 8'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        nib_m = shadow_nib_q;
        dp_m  = shadow_dp_q;
        err_m = shadow_err_q;
        for (int i = 0; i < 4; i++) begin
            if (sel_mask[i]) begin
                nib_m[4*i +: 4] = glyph_nib;
                dp_m[i]         = ~disp_s_q[7];
                err_m[i]        = ~glyph_ok;
            end
        end
        seen_m = seen_q | sel_mask;
    end

    always_comb begin
        shadow_nib_d = shadow_nib_q;
        shadow_dp_d  = shadow_dp_q;
        shadow_err_d = shadow_err_q;
        seen_d       = seen_q;
        value_d      = value_q;
        dp_out_d     = dp_out_q;
        err_out_d    = err_out_q;
        fv_d         = 1'b0;
        vc_d         = 1'b0;
        commit       = 1'b0;
        if (capture) begin
            shadow_nib_d = nib_m;
            shadow_dp_d  = dp_m;
            shadow_err_d = err_m;
            seen_d       = seen_m;
            if (seen_m == 4'b1111) begin
                commit       = 1'b1;
                value_d      = nib_m;
                dp_out_d     = dp_m;
                err_out_d    = |err_m;
                fv_d         = 1'b1;
                vc_d         = (nib_m != value_q);
                seen_d       = 4'b0000;
                shadow_err_d = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_s_q      <= 4'hF;
            disp_s_q     <= 8'hFF;
            pos_p_q      <= 4'hF;
            disp_p_q     <= 8'hFF;
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            shadow_nib_q <= 16'h0000;
            shadow_dp_q  <= 4'h0;
            shadow_err_q <= 4'h0;
            seen_q       <= 4'h0;
            value_q      <= 16'h0000;
            dp_out_q     <= 4'h0;
            err_out_q    <= 1'b0;
            fv_q         <= 1'b0;
            vc_q         <= 1'b0;
        end else begin
            pos_s_q      <= pos_s_d;
            disp_s_q     <= disp_s_d;
            pos_p_q      <= pos_p_d;
            disp_p_q     <= disp_p_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_nib_q <= shadow_nib_d;
            shadow_dp_q  <= shadow_dp_d;
            shadow_err_q <= shadow_err_d;
            seen_q       <= seen_d;
            value_q      <= value_d;
            dp_out_q     <= dp_out_d;
            err_out_q    <= err_out_d;
            fv_q         <= fv_d;
            vc_q         <= vc_d;
        end
    end

`ifdef SEGSCAN_STALE_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        stale_q, stale_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        stale_d  = stale_q;
        if (commit) begin
            wd_cnt_d = 32'd0;
            stale_d  = 1'b0;
        end else begin
            if (wd_cnt_q != TIMEOUT_W) begin
                wd_cnt_d = wd_cnt_q + 32'd1;
            end
            stale_d = stale_q | (wd_cnt_d == TIMEOUT_W);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= 32'd0;
            stale_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            stale_q  <= stale_d;
        end
    end

    assign stale = stale_q;
`else
    logic unused_cfg;
    assign unused_cfg = commit ^ (^TIMEOUT_W);
    assign stale      = 1'b0;
`endif

    assign value         = value_q;
    assign dp            = dp_out_q;
    assign decode_err    = err_out_q;
    assign frame_valid   = fv_q;
    assign value_changed = vc_q;

endmodule
